// File: rtl/instr_mem_responder.sv
// instr_mem_responder: instruction-fetch memory responder.
// Returns one 16-bit word per accepted fetch strobe from a 256x16 array
// mapped at 16'h3000-16'h30FF. Addresses outside that window return 16'h0000
// and raise addr_err. The array can be preloaded in any state, including
// reset, and its contents survive reset.
//
// Optional feature: define IMEM_WAIT_STATE_EN to insert one WAIT cycle per
// fetch (latency 2, imem_busy driven). When undefined, latency is 1 and
// imem_busy stays 0.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high reset
//   pc           fetch address
//   instrmem_rd  fetch read strobe
//   load_en      preload write enable
//   load_addr    preload word index (address 16'h3000 + index)
//   load_data    preload write data
//   instr_dout   returned instruction word (held between responses)
//   instr_valid  instr_dout valid this cycle
//   imem_busy    responder in wait state; strobes ignored
//   addr_err     returned word came from an out-of-range address
module instr_mem_responder (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [15:0] load_data,
  output logic [15:0] instr_dout,
  output logic        instr_valid,
  output logic        imem_busy,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 256;
  localparam logic [7:0]  PAGE  = 8'h30;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [15:0] mem [DEPTH];
  logic        pc_in_range;

  assign pc_in_range = (pc[15:8] == PAGE);

  // Preload port; not touched by reset. Reads in the FSM below see the
  // pre-write value when both hit the same index on the same edge.
  always_ff @(posedge clock) begin
    if (load_en) mem[load_addr] <= load_data;
  end

`ifdef IMEM_WAIT_STATE_EN
  logic [7:0] lat_idx;
  logic       lat_oor;

  // Fetch FSM with one wait cycle between accept and response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      instr_dout  <= 16'h0000;
      instr_valid <= 1'b0;
      imem_busy   <= 1'b0;
      addr_err    <= 1'b0;
      lat_idx     <= 8'h00;
      lat_oor     <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      imem_busy   <= 1'b0;
      addr_err    <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (instrmem_rd) begin
            state     <= WAIT;
            imem_busy <= 1'b1;
            lat_idx   <= pc[7:0];
            lat_oor   <= ~pc_in_range;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          // Strobes arriving here are dropped; the latched address stands.
          state       <= RESP;
          instr_valid <= 1'b1;
          instr_dout  <= lat_oor ? 16'h0000 : mem[lat_idx];
          addr_err    <= lat_oor;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // Fetch FSM responding on the edge right after the strobe; WAIT unused.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      instr_dout  <= 16'h0000;
      instr_valid <= 1'b0;
      imem_busy   <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      imem_busy   <= 1'b0;
      addr_err    <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (instrmem_rd) begin
            state       <= RESP;
            instr_valid <= 1'b1;
            instr_dout  <= pc_in_range ? mem[pc[7:0]] : 16'h0000;
            addr_err    <= ~pc_in_range;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized self-checking bench for instr_mem_responder. A transaction-level
// model (word array plus a pending-fetch record) predicts every output each
// cycle; a few directed sequences add constant-value checks.
module tb_instr_mem_responder;

`ifdef IMEM_WAIT_STATE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic [15:0] instr_dout;
  logic        instr_valid;
  logic        imem_busy;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_mem [256];
  logic        pend;
  logic [15:0] pend_pc;
  logic [15:0] e_dout;
  logic        e_valid, e_busy, e_err;

  instr_mem_responder dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .instrmem_rd (instrmem_rd),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .instr_dout  (instr_dout),
    .instr_valid (instr_valid),
    .imem_busy   (imem_busy),
    .addr_err    (addr_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // {err, data} returned for a fetch of address a, from current model memory.
  function automatic logic [16:0] lookup(input logic [15:0] a);
    if (a[15:8] == 8'h30) return {1'b0, m_mem[a[7:0]]};
    return {1'b1, 16'h0000};
  endfunction

  // Advance the model by one rising edge given the inputs sampled there.
  task automatic model_step(input logic r, input logic rd, input logic [15:0] p,
                            input logic le, input logic [7:0] la, input logic [15:0] ld);
    logic [16:0] res;
    e_valid = 1'b0;
    e_busy  = 1'b0;
    e_err   = 1'b0;
    if (r) begin
      pend   = 1'b0;
      e_dout = 16'h0000;
    end else if (pend) begin
      res     = lookup(pend_pc);
      e_valid = 1'b1;
      e_dout  = res[15:0];
      e_err   = res[16];
      pend    = 1'b0;
    end else if (rd) begin
      if (LAT == 1) begin
        res     = lookup(p);
        e_valid = 1'b1;
        e_dout  = res[15:0];
        e_err   = res[16];
      end else begin
        pend    = 1'b1;
        pend_pc = p;
        e_busy  = 1'b1;
      end
    end
    // Write lands after the read: same-edge reads see old data.
    if (le) m_mem[la] = ld;
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs mid-cycle.
  task automatic cycle(input logic r, input logic rd, input logic [15:0] p,
                       input logic le, input logic [7:0] la, input logic [15:0] ld,
                       input string tag);
    reset = r; instrmem_rd = rd; pc = p;
    load_en = le; load_addr = la; load_data = ld;
    @(posedge clock);
    model_step(r, rd, p, le, la, ld);
    @(negedge clock);
    check({tag, "_valid"}, {15'b0, instr_valid}, {15'b0, e_valid});
    check({tag, "_busy"},  {15'b0, imem_busy},   {15'b0, e_busy});
    check({tag, "_err"},   {15'b0, addr_err},    {15'b0, e_err});
    check({tag, "_dout"},  instr_dout,           e_dout);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, tag);
  endtask

  initial begin
    pend = 1'b0; pend_pc = 16'h0000;
    e_dout = 16'h0000; e_valid = 1'b0; e_busy = 1'b0; e_err = 1'b0;

    // Reset state, with preload of every word happening under reset.
    for (int i = 0; i < 256; i++)
      cycle(1'b1, 1'b1, 16'h3000, 1'b1, 8'(i), 16'($urandom), "pre");
    check("rst_valid", {15'b0, instr_valid}, 16'h0000);
    check("rst_dout",  instr_dout,           16'h0000);

    // Basic fetch of a preloaded word.
    cycle(1'b0, 1'b0, 16'h0000, 1'b1, 8'h05, 16'h1234, "load05");
    cycle(1'b0, 1'b1, 16'h3005, 1'b0, 8'h00, 16'h0000, "rd3005");
`ifdef IMEM_WAIT_STATE_EN
    check("wait_busy", {15'b0, imem_busy}, 16'h0001);
    cycle(1'b0, 1'b1, 16'h3006, 1'b0, 8'h00, 16'h0000, "ign3006");
`endif
    check("rd3005_const", instr_dout, 16'h1234);
    check("rd3005_vconst", {15'b0, instr_valid}, 16'h0001);
    idle("idle1");

    // Out-of-range fetch.
    cycle(1'b0, 1'b1, 16'h4000, 1'b0, 8'h00, 16'h0000, "rd4000");
    if (LAT == 2) idle("w4000");
    check("oor_err_const",  {15'b0, addr_err}, 16'h0001);
    check("oor_dout_const", instr_dout, 16'h0000);
    idle("idle2");

    // Back-to-back strobes.
    cycle(1'b0, 1'b1, 16'h3000, 1'b0, 8'h00, 16'h0000, "b2b0");
    cycle(1'b0, 1'b1, 16'h3001, 1'b0, 8'h00, 16'h0000, "b2b1");
    cycle(1'b0, 1'b1, 16'h3002, 1'b0, 8'h00, 16'h0000, "b2b2");
    for (int i = 0; i < 3; i++) idle("b2b_tail");

    // Reset in the middle of a read, then contents retained.
    cycle(1'b0, 1'b1, 16'h3005, 1'b0, 8'h00, 16'h0000, "rstmid_rd");
    cycle(1'b1, 1'b1, 16'h3005, 1'b0, 8'h00, 16'h0000, "rstmid_rst");
    check("rstmid_valid_const", {15'b0, instr_valid}, 16'h0000);
    for (int i = 0; i < 3; i++) idle("rstmid_tail");
    cycle(1'b0, 1'b1, 16'h3005, 1'b0, 8'h00, 16'h0000, "reread");
    if (LAT == 2) idle("reread_w");
    check("reread_const", instr_dout, 16'h1234);
    idle("idle3");

    // Same-edge load and read of one index.
    cycle(1'b0, 1'b1, 16'h3005, 1'b1, 8'h05, 16'hBEEF, "rw_same");
`ifndef IMEM_WAIT_STATE_EN
    check("rw_old_const", instr_dout, 16'h1234);
`endif
    idle("rw_idle");
    cycle(1'b0, 1'b1, 16'h3005, 1'b0, 8'h00, 16'h0000, "rw_new");
    if (LAT == 2) idle("rw_new_w");
    check("rw_new_const", instr_dout, 16'hBEEF);
    idle("idle4");

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic        r, rd, le;
      logic [15:0] p;
      r  = ($urandom_range(0, 39) == 0);
      rd = ($urandom_range(0, 9) < 6);
      le = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) p = 16'($urandom);
      else                           p = {8'h30, 8'($urandom)};
      cycle(r, rd, p, le, 8'($urandom), 16'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
